// File: rtl/truthtable_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : truthtable_sweep_checker
// Purpose  : Sweeps every input combination into a truth-table block, samples
//            its output after a settle time and checks it against EXP_TABLE.
//            Optional macro TTCHK_STOP_ON_ERR_EN ends the sweep at the first
//            mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module truthtable_sweep_checker #(
    parameter int                   N_IN      = 3,
    parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 8'hAC,
    parameter int                   SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      x,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 first_err_valid,
    output logic [(1<<N_IN)-1:0] cap_table
);

    localparam int              c_DEPTH   = 1 << N_IN;
    localparam logic [N_IN-1:0] c_LAST    = N_IN'(c_DEPTH - 1);
    localparam logic [N_IN-1:0] c_X_ONE   = N_IN'(1);
    localparam logic [N_IN:0]   c_ERR_ONE = (N_IN + 1)'(1);
    localparam logic [3:0]      c_SETTLE  = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [N_IN-1:0]        r_x, w_x_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic [N_IN:0]          r_err_count, w_err_count_nxt;
    logic [N_IN-1:0]        r_first_err_idx, w_first_err_idx_nxt;
    logic                   r_first_err_valid, w_first_err_valid_nxt;
    logic [c_DEPTH-1:0]     r_cap_table, w_cap_table_nxt;
    logic                   w_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_x               <= '0;
            r_cnt             <= '0;
            r_err_count       <= '0;
            r_first_err_idx   <= '0;
            r_first_err_valid <= 1'b0;
            r_cap_table       <= '0;
        end else begin
            r_state           <= w_state_nxt;
            r_x               <= w_x_nxt;
            r_cnt             <= w_cnt_nxt;
            r_err_count       <= w_err_count_nxt;
            r_first_err_idx   <= w_first_err_idx_nxt;
            r_first_err_valid <= w_first_err_valid_nxt;
            r_cap_table       <= w_cap_table_nxt;
        end
    end

    // An X on f_in makes this compare unknown, which the if below treats as a match.
    assign w_mismatch = (f_in != EXP_TABLE[r_x]);

    always_comb begin
        w_state_nxt           = r_state;
        w_x_nxt               = r_x;
        w_cnt_nxt             = r_cnt;
        w_err_count_nxt       = r_err_count;
        w_first_err_idx_nxt   = r_first_err_idx;
        w_first_err_valid_nxt = r_first_err_valid;
        w_cap_table_nxt       = r_cap_table;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt           = S_DRIVE;
                    w_x_nxt               = '0;
                    w_cnt_nxt             = '0;
                    w_err_count_nxt       = '0;
                    w_first_err_idx_nxt   = '0;
                    w_first_err_valid_nxt = 1'b0;
                    w_cap_table_nxt       = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == c_SETTLE) begin
                    w_cap_table_nxt[r_x] = f_in;
                    if (w_mismatch) begin
                        w_err_count_nxt = r_err_count + c_ERR_ONE;
                        if (!r_first_err_valid) begin
                            w_first_err_idx_nxt   = r_x;
                            w_first_err_valid_nxt = 1'b1;
                        end
                    end
`ifdef TTCHK_STOP_ON_ERR_EN
                    if (w_mismatch || (r_x == c_LAST)) begin
`else
                    if (r_x == c_LAST) begin
`endif
                        w_state_nxt = S_DONE;
                    end else begin
                        w_x_nxt   = r_x + c_X_ONE;
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign x               = r_x;
    assign busy            = (r_state == S_DRIVE);
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_err_count == '0);
    assign err_count       = r_err_count;
    assign first_err_idx   = r_first_err_idx;
    assign first_err_valid = r_first_err_valid;
    assign cap_table       = r_cap_table;

endmodule
`default_nettype wire

// File: tb/tb_truthtable_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_truthtable_sweep_checker
// Purpose  : Self-checking bench; two checkers (SETTLE=1 and SETTLE=0) sweep
//            directed and random target tables against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truthtable_sweep_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] x_a, x_b;
    logic       f_a, f_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0] err_a, err_b;
    logic [2:0] fidx_a, fidx_b;
    logic       fval_a, fval_b;
    logic [7:0] cap_a, cap_b;

    logic [7:0] tgt = 8'h00;
    logic [7:0] exp_tab;
    bit         sel = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // The block under check is a combinational lookup of the current vector.
    assign f_a = tgt[x_a];
    assign f_b = tgt[x_b];

    truthtable_sweep_checker #(.N_IN(3), .EXP_TABLE(8'hAC), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .x(x_a), .f_in(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_idx(fidx_a), .first_err_valid(fval_a), .cap_table(cap_a)
    );

    truthtable_sweep_checker #(.N_IN(3), .EXP_TABLE(8'hAC), .SETTLE(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .x(x_b), .f_in(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_idx(fidx_b), .first_err_valid(fval_b), .cap_table(cap_b)
    );

    wire [2:0] obs_x    = sel ? x_b    : x_a;
    wire       obs_busy = sel ? busy_b : busy_a;
    wire       obs_done = sel ? done_b : done_a;
    wire       obs_pass = sel ? pass_b : pass_a;
    wire [3:0] obs_err  = sel ? err_b  : err_a;
    wire [2:0] obs_fidx = sel ? fidx_b : fidx_a;
    wire       obs_fval = sel ? fval_b : fval_a;
    wire [7:0] obs_cap  = sel ? cap_b  : cap_a;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"},    32'(obs_x),    0);
        chk({tag, "_busy"}, 32'(obs_busy), 0);
        chk({tag, "_done"}, 32'(obs_done), 0);
        chk({tag, "_pass"}, 32'(obs_pass), 0);
        chk({tag, "_err"},  32'(obs_err),  0);
        chk({tag, "_fidx"}, 32'(obs_fidx), 0);
        chk({tag, "_fval"}, 32'(obs_fval), 0);
        chk({tag, "_cap"},  32'(obs_cap),  0);
    endtask

    // Full sweep with expectations derived from the mismatch set of the target table.
    task automatic run_sweep(input bit s, input logic [7:0] tab, input int pulse_at, input string tag);
        int         period, nvec, k, nerr, first;
        logic [7:0] mism, cap_exp;
        int         x_last;
        sel    = s;
        tgt    = tab;
        period = s ? 1 : 2;
        mism   = tab ^ exp_tab;
        nerr   = 0;
        first  = -1;
        for (int i = 0; i < 8; i++) begin
            if (mism[i]) begin
                if (first < 0) first = i;
                nerr++;
            end
        end
        nvec    = 8;
        cap_exp = tab;
        x_last  = 7;
`ifdef TTCHK_STOP_ON_ERR_EN
        if (first >= 0) begin
            nvec    = first + 1;
            nerr    = 1;
            cap_exp = tab & 8'((1 << (first + 1)) - 1);
            x_last  = first;
        end
`endif
        set_start(1'b1);
        tick;
        set_start(1'b0);
        chk({tag, "_busy_rise"}, 32'(obs_busy), 1);
        k = 0;
        while (obs_done !== 1'b1 && k < 200) begin
            chk({tag, "_x_seq"}, 32'(obs_x), 32'(k / period));
            if (k == pulse_at) set_start(1'b1);
            tick;
            set_start(1'b0);
            k++;
        end
        chk({tag, "_latency"}, 32'(k),        32'(nvec * period));
        chk({tag, "_cap"},     32'(obs_cap),  32'(cap_exp));
        chk({tag, "_err"},     32'(obs_err),  32'(nerr));
        chk({tag, "_fval"},    32'(obs_fval), (first >= 0) ? 1 : 0);
        chk({tag, "_fidx"},    32'(obs_fidx), (first >= 0) ? 32'(first) : 0);
        chk({tag, "_pass"},    32'(obs_pass), (nerr == 0) ? 1 : 0);
        chk({tag, "_busy"},    32'(obs_busy), 0);
        chk({tag, "_x_end"},   32'(obs_x),    32'(x_last));
        tick;
        tick;
        chk({tag, "_hold_done"}, 32'(obs_done), 1);
        chk({tag, "_hold_cap"},  32'(obs_cap),  32'(cap_exp));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 8; i++) begin
            exp_tab[i] = (!i[2] && i[1]) || (i[2] && i[0]);
        end

        tick;
        tick;
        sel = 1'b0;
        chk_reset_state("rst_a");
        sel = 1'b1;
        chk_reset_state("rst_b");
        reset = 1'b0;
        tick;

        run_sweep(1'b0, exp_tab,  -1, "correct");
        run_sweep(1'b0, 8'h00,    -1, "tied0");
        run_sweep(1'b0, ~exp_tab, -1, "inverted");
        run_sweep(1'b1, exp_tab,   3, "settle0_pulse");
        run_sweep(1'b0, 8'hFF,    -1, "tied1");

        for (int r = 0; r < 6; r++) begin
            run_sweep(bit'(r % 2), 8'($urandom), 32'($urandom_range(0, 6)), "random");
        end

        // Abort mid-sweep once x reaches 4, then verify a clean restart.
        sel     = 1'b0;
        tgt     = exp_tab;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        k = 0;
        while (obs_x !== 3'd4 && k < 50) begin
            tick;
            k++;
        end
        chk("reach_x4", 32'(obs_x), 4);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_reset_state("midrst");
        tick;
        run_sweep(1'b0, exp_tab, -1, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truthtable_sweep_checker.md
Name: truthtable_sweep_checker

Overview:
- Sequential, self-contained stimulus-and-check engine for small combinational or registered truth-table blocks.
- On `start`, it drives every input combination `{x[N_IN-1], ..., x[0]}` from 0 up to 2^N_IN-1 into the block under check.
- For each combination it samples the block's single output `f_in` after a programmable settle time, records it into a captured truth table, and compares it against `EXP_TABLE`.
- Reports mismatch count, first failing index and pass/fail. It sits on the stimulus side of a truth-table function block in a self-test harness.

Parameters:
- N_IN, 3, number of function inputs (1..6); table depth = 2^N_IN.
- EXP_TABLE, 8'hAC, expected output per index, bit i = f for input value i; width 2^N_IN. Default is f = (~x3 & x2) | (x3 & x1).
- SETTLE, 1, extra cycles each vector is held before `f_in` is sampled (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; single-cycle pulse or level, sampled in IDLE/DONE only
- x  output  N_IN  drives the inputs of the block under check; x[N_IN-1] maps to x3 for N_IN=3
- f_in  input  1  output of the block under check
- busy  output  1  sweep in progress
- done  output  1  sweep complete; results valid and held
- pass  output  1  done and err_count==0
- err_count  output  N_IN+1  number of mismatching indices, 0..2^N_IN
- first_err_idx  output  N_IN  lowest index that mismatched; valid when first_err_valid=1
- first_err_valid  output  1  at least one mismatch recorded
- cap_table  output  2^N_IN  captured f per index, bit i = sample for x=i

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, x=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, cap_table=0, settle counter=0.
- States:
  - IDLE: start=1 → DRIVE. On that edge, clear all results and the settle counter, and set x=0.
  - DRIVE: busy=1; x holds the current index. The settle counter increments each cycle.
    - On the cycle where counter==SETTLE, `f_in` is sampled at the next rising edge.
    - That edge writes cap_table[x] = f_in.
    - If f_in != EXP_TABLE[x]: err_count increments. If first_err_valid=0, it also sets first_err_idx=x and first_err_valid=1.
    - If x==2^N_IN-1: go to DONE. Otherwise x increments and the counter clears.
  - DONE: busy=0, done=1, pass=(err_count==0); x holds 2^N_IN-1. start=1 → DRIVE (restart, same as from IDLE). All results stay held until restart or reset.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - With SETTLE=0 the sample is taken in the same cycle x is driven (combinational target).
  - busy rises the cycle after start is seen.
  - done rises exactly 2^N_IN*(SETTLE+1) cycles after busy rises. For defaults: 16 cycles.
- start while busy: ignored, no restart.
- err_count width N_IN+1 so a full mismatch (2^N_IN) never wraps.
- The x increment never wraps mid-sweep; the final index exits to DONE.
- Reset asserted mid-sweep aborts immediately to IDLE with all outputs cleared. A sweep in progress is not resumed.
- An X on f_in is not interpreted; it is compared as sampled.

Optional Feature:
- Macro TTCHK_STOP_ON_ERR_EN.
- When defined: the first mismatch ends the sweep. DRIVE → DONE on the same edge that records it; err_count=1, first_err_idx set, x holds the failing index, and cap_table bits above that index remain 0.
- When not defined: the full sweep always runs, as described under Behaviour.

Test Plan:
- Correct target (f=(~x3&x2)|(x3&x1)), defaults, start pulse → x sequence 0..7, 2 cycles each; done after 16 cycles; cap_table=8'hAC, err_count=0, pass=1, first_err_valid=0.
- f_in tied 0 → cap_table=8'h00, err_count=4, first_err_idx=2, pass=0.
- f_in = ~expected → err_count=8 (no wrap, value 4'b1000), first_err_idx=0, cap_table=8'h53.
- SETTLE=0 with a combinational correct target → done 8 cycles after busy; cap_table=8'hAC. start pulsed at cycle 3 of the sweep is ignored (x sequence undisturbed).
- reset asserted at x=4 mid-sweep → next cycle all outputs 0, state IDLE. A subsequent start yields a clean full sweep with pass=1.
- TTCHK_STOP_ON_ERR_EN, f_in tied 1 → DONE right after index 0 is sampled; err_count=1, first_err_idx=0, x=0, cap_table=8'h01, pass=0.
